// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the MEM-stage port (P), the loader/debug port (D) and dmem.
// slave: the arbiter; master: the requesters plus memory that surround it.
interface dmem_arbiter_if;
    logic        PReq, PWE, PSign, PStall;
    logic [1:0]  PSize;
    logic [0:31] PAddr, PWData, PRData;
    logic        DReq, DWE, DSign, DDone;
    logic [1:0]  DSize;
    logic [0:31] DAddr, DWData, DRData;
    logic        MWE, MSign;
    logic [1:0]  MSize;
    logic [0:31] MAddr, MWData, MRData;

    modport slave (
        input  PReq, PWE, PSign, PSize, PAddr, PWData,
        input  DReq, DWE, DSign, DSize, DAddr, DWData,
        input  MRData,
        output PStall, PRData, DDone, DRData,
        output MAddr, MWData, MWE, MSize, MSign
    );

    modport master (
        output PReq, PWE, PSign, PSize, PAddr, PWData,
        output DReq, DWE, DSign, DSize, DAddr, DWData,
        output MRData,
        input  PStall, PRData, DDone, DRData,
        input  MAddr, MWData, MWE, MSize, MSign
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer sharing the single-ported dmem between
// the pipeline MEM port (P) and the loader/debug port (D).
module dmem_arbiter #(
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state, state_nxt;
    logic        owner_d, last_d;
    logic [CW-1:0] cnt;
    logic [0:31] lat_addr, lat_wdata;
    logic        lat_we, lat_sign;
    logic [1:0]  lat_size;
    logic [0:31] prdata_q, drdata_q;
    logic        grant, grant_d, final_cyc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // grant_d selects D; on a tie the port that did not win last time goes next.
    always_comb begin
        grant     = 1'b0;
        grant_d   = 1'b0;
        final_cyc = 1'b0;
        state_nxt = state;
        unique case (state)
            IDLE: begin
                grant   = bus.PReq | bus.DReq;
                grant_d = (bus.PReq & bus.DReq) ? ~last_d : bus.DReq;
                if (grant) state_nxt = ACCESS;
            end
            ACCESS: begin
                final_cyc = (cnt == '0);
                if (final_cyc) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.MWE    = final_cyc & lat_we;
        bus.DDone  = (state == DONE) & owner_d;
        bus.PStall = bus.PReq & ~((state == DONE) & ~owner_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_d   <= 1'b0;
            last_d    <= 1'b1;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
            lat_size  <= '0;
            lat_sign  <= 1'b0;
            prdata_q  <= '0;
            drdata_q  <= '0;
        end else begin
            if (grant) begin
                owner_d   <= grant_d;
                last_d    <= grant_d;
                cnt       <= CW'(LATENCY - 1);
                lat_addr  <= grant_d ? bus.DAddr  : bus.PAddr;
                lat_wdata <= grant_d ? bus.DWData : bus.PWData;
                lat_we    <= grant_d ? bus.DWE    : bus.PWE;
                lat_size  <= grant_d ? bus.DSize  : bus.PSize;
                lat_sign  <= grant_d ? bus.DSign  : bus.PSign;
            end else if (state == ACCESS && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
            // Loads capture on the last memory cycle; stores leave both read registers alone.
            if (final_cyc && !lat_we) begin
                if (owner_d) drdata_q <= bus.MRData;
                else         prdata_q <= bus.MRData;
            end
        end
    end

    assign bus.MAddr  = lat_addr;
    assign bus.MWData = lat_wdata;
    assign bus.MSize  = lat_size;
    assign bus.MSign  = lat_sign;
    assign bus.PRData = prdata_q;
    assign bus.DRData = drdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: three instances (LATENCY 1,2,3) checked each cycle against
// a transaction-countdown model, with directed literal checks followed by random traffic.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [3];
    logic        preq [3], pwe [3], psign [3];
    logic [1:0]  psize [3];
    logic [0:31] paddr [3], pwdata [3];
    logic        dreq [3], dwe [3], dsign [3];
    logic [1:0]  dsize [3];
    logic [0:31] daddr [3], dwdata [3];
    logic [0:31] mrdata [3];

    logic        pstall [3], ddone [3], mwe [3], msign [3];
    logic [1:0]  msize [3];
    logic [0:31] prdata [3], drdata [3], maddr [3], mwdata [3];

    for (genvar g = 0; g < 3; g++) begin : lane
        dmem_arbiter_if bus ();
        assign bus.PReq   = preq[g];
        assign bus.PWE    = pwe[g];
        assign bus.PSign  = psign[g];
        assign bus.PSize  = psize[g];
        assign bus.PAddr  = paddr[g];
        assign bus.PWData = pwdata[g];
        assign bus.DReq   = dreq[g];
        assign bus.DWE    = dwe[g];
        assign bus.DSign  = dsign[g];
        assign bus.DSize  = dsize[g];
        assign bus.DAddr  = daddr[g];
        assign bus.DWData = dwdata[g];
        assign bus.MRData = mrdata[g];

        dmem_arbiter #(.LATENCY(g + 1)) u_dut (
            .clk   (clk),
            .reset (rst[g]),
            .bus   (bus.slave)
        );

        assign pstall[g] = bus.PStall;
        assign prdata[g] = bus.PRData;
        assign ddone[g]  = bus.DDone;
        assign drdata[g] = bus.DRData;
        assign maddr[g]  = bus.MAddr;
        assign mwdata[g] = bus.MWData;
        assign mwe[g]    = bus.MWE;
        assign msize[g]  = bus.MSize;
        assign msign[g]  = bus.MSign;
    end

    // Model: rem counts cycles left in the current transaction (0 = free).
    // A grant loads LATENCY+1; rem==2 is the last memory cycle, rem==1 the completion cycle.
    int          rem [3];
    logic        own_d [3], last_d [3], m_we [3], m_sign [3];
    logic [1:0]  m_size [3];
    logic [0:31] m_addr [3], m_wdata [3], m_prd [3], m_drd [3];
    logic        p_fin [3], d_fin [3];

    int n_vec = 0;
    int n_err = 0;

    task automatic cmp(input string nm, input int l, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s lane%0d t=%0t: got %h expected %h", nm, l, $time, got, exp);
        end
    endtask

    task automatic model_reset(input int l);
        rem[l] = 0;  own_d[l] = 1'b0;  last_d[l] = 1'b1;
        m_we[l] = 1'b0;  m_sign[l] = 1'b0;  m_size[l] = '0;
        m_addr[l] = '0;  m_wdata[l] = '0;  m_prd[l] = '0;  m_drd[l] = '0;
    endtask

    task automatic model_step(input int l);
        logic d;
        if (rem[l] == 0) begin
            if (preq[l] || dreq[l]) begin
                d = (preq[l] && dreq[l]) ? ~last_d[l] : dreq[l];
                own_d[l]   = d;
                last_d[l]  = d;
                m_addr[l]  = d ? daddr[l]  : paddr[l];
                m_wdata[l] = d ? dwdata[l] : pwdata[l];
                m_we[l]    = d ? dwe[l]    : pwe[l];
                m_size[l]  = d ? dsize[l]  : psize[l];
                m_sign[l]  = d ? dsign[l]  : psign[l];
                rem[l]     = l + 2;
            end
        end else begin
            if (rem[l] == 2 && !m_we[l]) begin
                if (own_d[l]) m_drd[l] = mrdata[l];
                else          m_prd[l] = mrdata[l];
            end
            if (rem[l] == 1) begin
                if (own_d[l]) d_fin[l] = 1'b1;
                else          p_fin[l] = 1'b1;
            end
            rem[l]--;
        end
    endtask

    task automatic check_all();
        logic e_done, e_final;
        for (int l = 0; l < 3; l++) begin
            if (!rst[l]) model_reset(l);
            e_done  = (rem[l] == 1);
            e_final = (rem[l] == 2);
            cmp("pstall", l, pstall[l], preq[l] & ~(e_done & ~own_d[l]));
            cmp("ddone",  l, ddone[l],  e_done & own_d[l]);
            cmp("mwe",    l, mwe[l],    e_final & m_we[l]);
            cmp("maddr",  l, maddr[l],  m_addr[l]);
            cmp("mwdata", l, mwdata[l], m_wdata[l]);
            cmp("msize",  l, msize[l],  m_size[l]);
            cmp("msign",  l, msign[l],  m_sign[l]);
            cmp("prdata", l, prdata[l], m_prd[l]);
            cmp("drdata", l, drdata[l], m_drd[l]);
        end
    endtask

    // Called right after a falling edge with inputs set; returns at the next falling edge.
    task automatic tick();
        #1;
        check_all();
        @(posedge clk);
        for (int l = 0; l < 3; l++) if (rst[l]) model_step(l);
        @(negedge clk);
    endtask

    task automatic set_p(input logic r, input logic we, input logic [1:0] sz,
                         input logic [0:31] a, input logic [0:31] wd);
        for (int l = 0; l < 3; l++) begin
            preq[l] = r;  pwe[l] = we;  psize[l] = sz;  paddr[l] = a;  pwdata[l] = wd;  psign[l] = 1'b0;
        end
    endtask

    task automatic set_d(input logic r, input logic we, input logic [1:0] sz,
                         input logic [0:31] a, input logic [0:31] wd);
        for (int l = 0; l < 3; l++) begin
            dreq[l] = r;  dwe[l] = we;  dsize[l] = sz;  daddr[l] = a;  dwdata[l] = wd;  dsign[l] = 1'b0;
        end
    endtask

    task automatic set_mr(input logic [0:31] v);
        for (int l = 0; l < 3; l++) mrdata[l] = v;
    endtask

    task automatic idle(input int n);
        set_p(1'b0, 1'b0, 2'd0, '0, '0);
        set_d(1'b0, 1'b0, 2'd0, '0, '0);
        repeat (n) tick();
    endtask

    // Requesters hold a request until their completion cycle, then drop or re-request.
    task automatic rand_drive(input int l);
        if (!preq[l] || p_fin[l]) begin
            preq[l]  = ($urandom_range(0, 2) == 0);
            pwe[l]   = $urandom_range(0, 1);
            psign[l] = $urandom_range(0, 1);
            psize[l] = 2'($urandom_range(0, 3));
            paddr[l] = $urandom;
            pwdata[l] = $urandom;
        end else if ($urandom_range(0, 29) == 0) begin
            preq[l] = 1'b0;
        end
        if (!dreq[l] || d_fin[l]) begin
            dreq[l]  = ($urandom_range(0, 2) == 0);
            dwe[l]   = $urandom_range(0, 1);
            dsign[l] = $urandom_range(0, 1);
            dsize[l] = 2'($urandom_range(0, 3));
            daddr[l] = $urandom;
            dwdata[l] = $urandom;
        end else if ($urandom_range(0, 29) == 0) begin
            dreq[l] = 1'b0;
        end
        p_fin[l]  = 1'b0;
        d_fin[l]  = 1'b0;
        mrdata[l] = $urandom;
        rst[l]    = ($urandom_range(0, 199) != 0);
    endtask

    initial begin
        for (int l = 0; l < 3; l++) begin
            rst[l] = 1'b0;  p_fin[l] = 1'b0;  d_fin[l] = 1'b0;
            model_reset(l);
        end
        set_p(1'b1, 1'b0, 2'd0, '0, '0);
        set_d(1'b0, 1'b0, 2'd0, '0, '0);
        set_mr('0);
        @(negedge clk);

        // Reset held with PReq high: everything 0 except PStall.
        repeat (2) begin
            #1;
            cmp("lit_rst_pstall", 1, pstall[1], 1);
            cmp("lit_rst_mwe",    1, mwe[1],    0);
            cmp("lit_rst_ddone",  1, ddone[1],  0);
            cmp("lit_rst_maddr",  1, maddr[1],  0);
            cmp("lit_rst_prdata", 1, prdata[1], 0);
            tick();
        end
        for (int l = 0; l < 3; l++) rst[l] = 1'b1;
        set_p(1'b0, 1'b0, 2'd0, '0, '0);
        repeat (3) begin
            #1;
            cmp("lit_idle_mwe", 1, mwe[1], 0);
            tick();
        end

        // P load, LATENCY=2.
        set_p(1'b1, 1'b0, 2'd2, 32'h100, '0);
        set_mr(32'hDEADBEEF);
        #1; cmp("lit_ld_stall0", 1, pstall[1], 1); tick();
        for (int c = 1; c <= 2; c++) begin
            #1;
            cmp("lit_ld_stall", 1, pstall[1], 1);
            cmp("lit_ld_maddr", 1, maddr[1], 32'h100);
            tick();
        end
        #1;
        cmp("lit_ld_prdata", 1, prdata[1], 32'hDEADBEEF);
        cmp("lit_ld_stall3", 1, pstall[1], 0);
        tick();
        idle(5);

        // P store: strobe only in the final access cycle, PRData untouched.
        set_p(1'b1, 1'b1, 2'd2, 32'h20, 32'h12345678);
        set_mr(32'h55555555);
        tick();
        #1; cmp("lit_st_mwe1", 1, mwe[1], 0); tick();
        #1;
        cmp("lit_st_mwe2",   1, mwe[1],    1);
        cmp("lit_st_maddr",  1, maddr[1],  32'h20);
        cmp("lit_st_mwdata", 1, mwdata[1], 32'h12345678);
        cmp("lit_st_msize",  1, msize[1],  2);
        tick();
        #1;
        cmp("lit_st_mwe3",   1, mwe[1],    0);
        cmp("lit_st_prdata", 1, prdata[1], 32'hDEADBEEF);
        cmp("lit_st_stall3", 1, pstall[1], 0);
        tick();
        idle(5);

        // Tie straight after reset: P first, then D, then P again on the next tie.
        for (int l = 0; l < 3; l++) rst[l] = 1'b0;
        tick();
        for (int l = 0; l < 3; l++) rst[l] = 1'b1;
        set_p(1'b1, 1'b0, 2'd0, 32'h300, '0);
        set_d(1'b1, 1'b0, 2'd0, 32'h304, '0);
        set_mr(32'h11112222);
        repeat (3) tick();
        #1;
        cmp("lit_tie_pstall3", 1, pstall[1], 0);
        cmp("lit_tie_ddone3",  1, ddone[1],  0);
        tick();
        set_p(1'b0, 1'b0, 2'd0, '0, '0);
        repeat (2) tick();
        #1; cmp("lit_tie_ddone6", 1, ddone[1], 0); tick();
        #1;
        cmp("lit_tie_ddone7",  1, ddone[1],  1);
        cmp("lit_tie_drdata7", 1, drdata[1], 32'h11112222);
        tick();
        set_p(1'b1, 1'b0, 2'd0, 32'h308, '0);
        set_mr(32'h33334444);
        repeat (3) tick();
        #1;
        cmp("lit_tie2_pstall11", 1, pstall[1], 0);
        cmp("lit_tie2_ddone11",  1, ddone[1],  0);
        cmp("lit_tie2_prdata11", 1, prdata[1], 32'h33334444);
        tick();
        set_p(1'b0, 1'b0, 2'd0, '0, '0);
        repeat (3) tick();
        #1;
        cmp("lit_tie2_ddone15",  1, ddone[1],  1);
        cmp("lit_tie2_drdata15", 1, drdata[1], 32'h33334444);
        tick();
        idle(5);

        // D load with P idle, LATENCY=1.
        set_d(1'b1, 1'b0, 2'd0, 32'h40, '0);
        set_mr(32'hCAFEF00D);
        #1; cmp("lit_d_pstall0", 0, pstall[0], 0); tick();
        #1;
        cmp("lit_d_ddone1",  0, ddone[0],  0);
        cmp("lit_d_pstall1", 0, pstall[0], 0);
        tick();
        #1;
        cmp("lit_d_ddone2",  0, ddone[0],  1);
        cmp("lit_d_drdata2", 0, drdata[0], 32'hCAFEF00D);
        cmp("lit_d_pstall2", 0, pstall[0], 0);
        tick();
        set_d(1'b0, 1'b0, 2'd0, '0, '0);
        #1; cmp("lit_d_ddone3", 0, ddone[0], 0); tick();
        idle(5);

        // Async reset during the first access cycle of a LATENCY=3 store.
        set_p(1'b1, 1'b1, 2'd1, 32'h60, 32'hA5A5A5A5);
        tick();
        rst[2] = 1'b0;
        repeat (2) begin
            #1;
            cmp("lit_ar_mwe",    2, mwe[2],    0);
            cmp("lit_ar_maddr",  2, maddr[2],  0);
            cmp("lit_ar_pstall", 2, pstall[2], 1);
            tick();
        end
        rst[2] = 1'b1;
        set_p(1'b0, 1'b0, 2'd0, '0, '0);
        repeat (5) begin
            #1;
            cmp("lit_ar_ddone_after", 2, ddone[2], 0);
            cmp("lit_ar_mwe_after",   2, mwe[2],   0);
            tick();
        end

        // Random traffic, including flushes, dropped D requests and rare async resets.
        for (int l = 0; l < 3; l++) begin
            p_fin[l] = 1'b0;
            d_fin[l] = 1'b0;
        end
        repeat (1500) begin
            for (int l = 0; l < 3; l++) rand_drive(l);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
